// File: rtl/iob_eth_frame_reader.sv
// Bus initiator that polls the Ethernet core for received frames and streams the RX buffer out as 32-bit beats.
// Latency: POLL_CYCLES idle cycles between status polls; each bus access takes 2 cycles plus a 1-cycle gap before the next one.
// Backpressure: each beat is held until m_tready; no bus access is issued while a beat is pending.
// Optional build macro: ETH_FRAME_READER_CRC_EN adds an ETH_CRC read after the last beat and reports the verdict.

module iob_eth_frame_reader #(
    parameter int          POLL_CYCLES = 16,
    parameter int          MAX_BYTES   = 2047,
    parameter logic [31:0] CRC_GOOD    = 32'hC704DD7B,
    parameter int          ETH_ADDR_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst_int,
    input  logic                  en,
    output logic                  eth_valid,
    output logic [ETH_ADDR_W-1:0] eth_addr,
    output logic [3:0]            eth_wstrb,
    output logic [31:0]           eth_wdata,
    input  logic [31:0]           eth_rdata,
    input  logic                  eth_ready,
    output logic [31:0]           m_tdata,
    output logic [3:0]            m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [10:0]           frame_bytes,
    output logic                  frame_clipped,
    output logic                  frame_crc_ok
);

    // Ethernet core register map (word addresses) and RX buffer base
    localparam logic [ETH_ADDR_W-1:0] ADDR_STATUS   = ETH_ADDR_W'(0);
    localparam logic [ETH_ADDR_W-1:0] ADDR_RCVACK   = ETH_ADDR_W'(2);
    localparam logic [ETH_ADDR_W-1:0] ADDR_CRC      = ETH_ADDR_W'(6);
    localparam logic [ETH_ADDR_W-1:0] ADDR_RCV_SIZE = ETH_ADDR_W'(7);
    localparam logic [ETH_ADDR_W-1:0] ADDR_BUF      = ETH_ADDR_W'(12'h800);

    localparam logic [15:0] POLL_RELOAD = 16'(POLL_CYCLES - 1);
    localparam logic [10:0] MAX_N       = 11'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_STAT, S_RD_SIZE, S_RD_DATA, S_PUSH, S_RD_CRC, S_WR_ACK, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic        gap_q;      // forces eth_valid low for one cycle after each accepted access
    logic [10:0] n_q;
    logic [9:0]  nwords_q;
    logic [9:0]  k_q;
    logic        clip_q;
    logic [31:0] tdata_q;
    logic [10:0] bytes_q;

    logic        acc;
    logic        bus_req;
    logic        last_beat;
    logic [10:0] size_raw;
    logic [10:0] size_clip;
    logic [11:0] size_plus3;
    logic [3:0]  keep_last;

    assign acc        = eth_valid & eth_ready;
    assign size_raw   = eth_rdata[10:0];
    assign size_clip  = (size_raw > MAX_N) ? MAX_N : size_raw;
    assign size_plus3 = {1'b0, size_clip} + 12'd3;
    assign last_beat  = (k_q == (nwords_q - 10'd1));
    assign bus_req    = (state_q == S_RD_STAT) || (state_q == S_RD_SIZE) ||
                        (state_q == S_RD_DATA) || (state_q == S_RD_CRC)  ||
                        (state_q == S_WR_ACK);

    // Byte enables of the final beat follow the byte count modulo 4
    always_comb begin
        keep_last = 4'hF;
        case (n_q[1:0])
            2'd1:    keep_last = 4'h1;
            2'd2:    keep_last = 4'h3;
            2'd3:    keep_last = 4'h7;
            default: keep_last = 4'hF;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: bus states advance only on an accepted access
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (en && (cnt_q == 16'd0)) state_d = S_RD_STAT;
            S_RD_STAT: if (acc) state_d = eth_rdata[1] ? S_RD_SIZE : S_IDLE;
            S_RD_SIZE: if (acc) state_d = (size_clip == 11'd0) ? S_WR_ACK : S_RD_DATA;
            S_RD_DATA: if (acc) state_d = S_PUSH;
            S_PUSH: begin
                if (m_tready) begin
                    if (!last_beat) begin
                        state_d = S_RD_DATA;
                    end else begin
`ifdef ETH_FRAME_READER_CRC_EN
                        state_d = S_RD_CRC;
`else
                        state_d = S_WR_ACK;
`endif
                    end
                end
            end
            S_RD_CRC:  if (acc) state_d = S_WR_ACK;
            S_WR_ACK:  if (acc) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: poll counter, frame size/word index, captured read data and results
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            cnt_q    <= POLL_RELOAD;
            gap_q    <= 1'b0;
            n_q      <= 11'd0;
            nwords_q <= 10'd0;
            k_q      <= 10'd0;
            clip_q   <= 1'b0;
            tdata_q  <= 32'h0;
            bytes_q  <= 11'd0;
        end else begin
            gap_q <= acc;
            // Counter only runs in IDLE; any other state leaves it reloaded for the next wait
            if (state_q != S_IDLE)             cnt_q <= POLL_RELOAD;
            else if (en && (cnt_q != 16'd0))   cnt_q <= cnt_q - 16'd1;
            if ((state_q == S_RD_SIZE) && acc) begin
                n_q      <= size_clip;
                nwords_q <= size_plus3[11:2];
                k_q      <= 10'd0;
                clip_q   <= (size_raw > MAX_N);
            end
            if ((state_q == S_RD_DATA) && acc) tdata_q <= eth_rdata;
            if ((state_q == S_PUSH) && m_tready) k_q <= k_q + 10'd1;
            if ((state_q == S_WR_ACK) && acc) bytes_q <= n_q;
        end
    end

`ifdef ETH_FRAME_READER_CRC_EN
    logic crc_ok_q;

    // CRC verdict captured from the ETH_CRC read
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int)                             crc_ok_q <= 1'b0;
        else if ((state_q == S_RD_CRC) && acc)   crc_ok_q <= (eth_rdata == CRC_GOOD);
    end

    assign frame_crc_ok = (state_q == S_DONE) && crc_ok_q;
`else
    assign frame_crc_ok = 1'b1;
`endif

    assign m_tdata     = tdata_q;
    assign frame_bytes = bytes_q;

    // Output decode from the current state
    always_comb begin
        eth_valid     = bus_req && !gap_q;
        eth_addr      = '0;
        eth_wstrb     = 4'h0;
        eth_wdata     = 32'h0;
        m_tvalid      = 1'b0;
        m_tlast       = 1'b0;
        m_tkeep       = 4'h0;
        busy          = (state_q != S_IDLE);
        frame_done    = 1'b0;
        frame_clipped = 1'b0;
        case (state_q)
            S_RD_STAT: eth_addr = ADDR_STATUS;
            S_RD_SIZE: eth_addr = ADDR_RCV_SIZE;
            S_RD_DATA: eth_addr = ADDR_BUF | ETH_ADDR_W'(k_q[8:0]);
            S_RD_CRC:  eth_addr = ADDR_CRC;
            S_WR_ACK: begin
                eth_addr  = ADDR_RCVACK;
                eth_wstrb = 4'hF;
                eth_wdata = 32'h1;
            end
            S_PUSH: begin
                m_tvalid = 1'b1;
                m_tlast  = last_beat;
                m_tkeep  = last_beat ? keep_last : 4'hF;
            end
            S_DONE: begin
                frame_done    = 1'b1;
                frame_clipped = clip_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iob_eth_frame_reader.sv
// Directed bench for iob_eth_frame_reader with a behavioural Ethernet register slave and stream sink.

module tb_iob_eth_frame_reader;

    localparam int POLL = 4;
    localparam int MAXB = 1500;
    localparam logic [31:0] CRC_G = 32'hC704DD7B;

    logic        clk = 1'b0;
    logic        rst_int = 1'b1;
    logic        en = 1'b0;
    logic        eth_valid;
    logic [11:0] eth_addr;
    logic [3:0]  eth_wstrb;
    logic [31:0] eth_wdata;
    logic [31:0] eth_rdata;
    logic        eth_ready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        busy;
    logic        frame_done;
    logic [10:0] frame_bytes;
    logic        frame_clipped;
    logic        frame_crc_ok;

    int checks = 0;
    int errors = 0;

    iob_eth_frame_reader #(
        .POLL_CYCLES(POLL),
        .MAX_BYTES  (MAXB),
        .CRC_GOOD   (CRC_G),
        .ETH_ADDR_W (12)
    ) dut (
        .clk          (clk),
        .rst_int      (rst_int),
        .en           (en),
        .eth_valid    (eth_valid),
        .eth_addr     (eth_addr),
        .eth_wstrb    (eth_wstrb),
        .eth_wdata    (eth_wdata),
        .eth_rdata    (eth_rdata),
        .eth_ready    (eth_ready),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_bytes  (frame_bytes),
        .frame_clipped(frame_clipped),
        .frame_crc_ok (frame_crc_ok)
    );

    always #5 clk = ~clk;

    // Slave register contents (owned by tasks)
    logic [31:0] status_val = 32'h0;
    logic [31:0] size_val   = 32'h0;
    logic [31:0] crc_val    = CRC_G;
    int          ack_arm    = 0;

    // Monitor counters (owned by the monitor)
    int stat_rd = 0, size_rd = 0, data_rd = 0, crc_rd = 0, ack_cnt = 0, other_acc = 0;
    int addr_err = 0, hold_err = 0, overlap_err = 0, stall_err = 0, busy_rises = 0, cyc = 0;
    int stat_t[$];
    logic [31:0] beat_dat[$];
    logic [3:0]  beat_keep[$];
    logic        beat_last[$];

    // Slave acknowledges one cycle after a request appears
    always @(posedge clk or posedge rst_int) begin
        if (rst_int) eth_ready <= 1'b0;
        else         eth_ready <= eth_valid && !eth_ready;
    end

    // Slave read data; STATUS reports a frame only until it has been acknowledged
    always_comb begin
        eth_rdata = 32'h0;
        if (eth_addr == 12'd0)      eth_rdata = (ack_cnt == ack_arm) ? status_val : 32'h0;
        else if (eth_addr == 12'd7) eth_rdata = size_val;
        else if (eth_addr == 12'd6) eth_rdata = crc_val;
        else if (eth_addr[11])      eth_rdata = 32'hA5C30000 | {20'h0, eth_addr};
    end

    // Bus and stream monitor sampled on the falling edge
    logic        p_pend = 1'b0, s_pend = 1'b0, p_busy = 1'b0;
    logic [11:0] p_addr = '0;
    logic [3:0]  p_wstrb = '0, s_keep = '0;
    logic [31:0] p_wdata = '0, s_dat = '0;
    logic        s_last = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!rst_int) begin
            if (eth_valid && eth_ready) begin
                if (eth_wstrb == 4'h0) begin
                    if (eth_addr == 12'd0) begin
                        stat_rd++;
                        stat_t.push_back(cyc);
                    end else if (eth_addr == 12'd7) size_rd++;
                    else if (eth_addr == 12'd6) crc_rd++;
                    else if (eth_addr[11]) begin
                        if (eth_addr != 12'(12'h800 + data_rd)) addr_err++;
                        data_rd++;
                    end else other_acc++;
                end else if (eth_addr == 12'd2 && eth_wstrb == 4'hF && eth_wdata == 32'h1) begin
                    ack_cnt++;
                end else other_acc++;
            end
            if (p_pend && !(eth_valid && eth_addr == p_addr && eth_wstrb == p_wstrb && eth_wdata == p_wdata))
                hold_err++;
            if (m_tvalid && eth_valid) overlap_err++;
            if (s_pend && !(m_tvalid && m_tdata == s_dat && m_tkeep == s_keep && m_tlast == s_last))
                stall_err++;
            if (m_tvalid && m_tready) begin
                beat_dat.push_back(m_tdata);
                beat_keep.push_back(m_tkeep);
                beat_last.push_back(m_tlast);
            end
            if (busy && !p_busy) busy_rises++;
        end
        p_pend  = eth_valid && !eth_ready;
        p_addr  = eth_addr;
        p_wstrb = eth_wstrb;
        p_wdata = eth_wdata;
        s_pend  = m_tvalid && !m_tready;
        s_dat   = m_tdata;
        s_keep  = m_tkeep;
        s_last  = m_tlast;
        p_busy  = busy;
    end

    // Stimulus: arm one frame and run until frame_done or the cycle budget expires
    task automatic run_frame(input int size, input bit toggle, output bit done,
                             output logic [10:0] bytes, output bit clip, output bit crc);
        size_val = 32'(size);
        ack_arm  = ack_cnt;
        status_val = 32'h2;
        m_tready = 1'b1;
        en = 1'b1;
        done = 1'b0; bytes = '0; clip = 1'b0; crc = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(posedge clk); #1;
            if (toggle) m_tready = ~m_tready;
            @(negedge clk);
            if (frame_done) begin
                done = 1'b1; bytes = frame_bytes; clip = frame_clipped; crc = frame_crc_ok;
            end
        end
        en = 1'b0;
        status_val = 32'h0;
        m_tready = 1'b1;
        repeat (POLL + 6) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0 || eth_valid !== 1'b0) begin errors++; $display("FAIL reset_in: busy=%b eth_valid=%b want 0/0", busy, eth_valid); end
        repeat (3) @(negedge clk);
        rst_int = 1'b0;
        @(negedge clk);
        checks++; if (eth_valid !== 1'b0 || eth_wstrb !== 4'h0 || eth_addr !== 12'h0) begin errors++; $display("FAIL reset_bus: valid=%b wstrb=%h addr=%h want 0", eth_valid, eth_wstrb, eth_addr); end
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0) begin errors++; $display("FAIL reset_stream: tvalid=%b tdata=%h tlast=%b want 0", m_tvalid, m_tdata, m_tlast); end
        checks++; if (frame_done !== 1'b0 || frame_bytes !== 11'd0 || frame_clipped !== 1'b0) begin errors++; $display("FAIL reset_status: done=%b bytes=%0d clip=%b want 0", frame_done, frame_bytes, frame_clipped); end
    endtask

    task automatic test_idle_poll();
        int s0, t0, z0, b0;
        bit ok;
        s0 = stat_rd; t0 = stat_t.size(); b0 = busy_rises;
        z0 = size_rd + data_rd + crc_rd + ack_cnt + other_acc;
        status_val = 32'h0;
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (stat_rd - s0 >= 3) ok = 1'b1;
        end
        en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL poll_timeout: status reads=%0d want 3", stat_rd - s0); end
        if (ok) begin
            checks++; if (stat_t[t0+1] - stat_t[t0] != POLL + 2) begin errors++; $display("FAIL poll_gap1: got %0d want %0d", stat_t[t0+1] - stat_t[t0], POLL + 2); end
            checks++; if (stat_t[t0+2] - stat_t[t0+1] != POLL + 2) begin errors++; $display("FAIL poll_gap2: got %0d want %0d", stat_t[t0+2] - stat_t[t0+1], POLL + 2); end
        end
        repeat (30) @(negedge clk);
        checks++; if (stat_rd - s0 != 3) begin errors++; $display("FAIL poll_en_freeze: status reads=%0d want 3", stat_rd - s0); end
        checks++; if (size_rd + data_rd + crc_rd + ack_cnt + other_acc != z0) begin errors++; $display("FAIL poll_other: extra accesses=%0d want 0", size_rd + data_rd + crc_rd + ack_cnt + other_acc - z0); end
        checks++; if (busy_rises - b0 != 3) begin errors++; $display("FAIL poll_busy: pulses=%0d want 3", busy_rises - b0); end
    endtask

    task automatic test_frame_64();
        int b0, d0, a0, ae0, h0, o0, c0;
        bit done, clip, crc;
        logic [10:0] bytes;
        int bad;
        b0 = beat_dat.size(); d0 = data_rd; a0 = ack_cnt; ae0 = addr_err; h0 = hold_err; o0 = overlap_err; c0 = crc_rd;
        run_frame(64, 1'b0, done, bytes, clip, crc);
        checks++; if (!done) begin errors++; $display("FAIL f64_done: frame_done not seen"); end
        checks++; if (bytes !== 11'd64 || clip !== 1'b0) begin errors++; $display("FAIL f64_bytes: bytes=%0d clip=%b want 64/0", bytes, clip); end
        checks++; if (beat_dat.size() - b0 != 16 || data_rd - d0 != 16) begin errors++; $display("FAIL f64_count: beats=%0d reads=%0d want 16/16", beat_dat.size() - b0, data_rd - d0); end
        if (beat_dat.size() - b0 == 16) begin
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                if (beat_dat[b0+i] !== (32'hA5C30000 | (32'h800 + 32'(i)))) bad++;
                if (beat_last[b0+i] !== (i == 15)) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL f64_data: %0d bad data/tlast beats want 0", bad); end
            checks++; if (beat_keep[b0+15] !== 4'hF || beat_keep[b0] !== 4'hF) begin errors++; $display("FAIL f64_keep: last=%h first=%h want F/F", beat_keep[b0+15], beat_keep[b0]); end
        end
        checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL f64_ack: acks=%0d want 1", ack_cnt - a0); end
        checks++; if (addr_err != ae0 || hold_err != h0 || overlap_err != o0) begin errors++; $display("FAIL f64_bus: addr_err=%0d hold_err=%0d overlap=%0d want 0", addr_err - ae0, hold_err - h0, overlap_err - o0); end
`ifdef ETH_FRAME_READER_CRC_EN
        checks++; if (crc_rd - c0 != 1) begin errors++; $display("FAIL f64_crcrd: crc reads=%0d want 1", crc_rd - c0); end
`else
        checks++; if (crc_rd - c0 != 0 || crc !== 1'b1) begin errors++; $display("FAIL f64_crc: crc reads=%0d ok=%b want 0/1", crc_rd - c0, crc); end
`endif
    endtask

    task automatic test_frame_61_stall();
        int b0, d0, s0, o0, bad;
        bit done, clip, crc;
        logic [10:0] bytes;
        b0 = beat_dat.size(); d0 = data_rd; s0 = stall_err; o0 = overlap_err;
        run_frame(61, 1'b1, done, bytes, clip, crc);
        checks++; if (!done || bytes !== 11'd61) begin errors++; $display("FAIL f61_done: done=%b bytes=%0d want 1/61", done, bytes); end
        checks++; if (beat_dat.size() - b0 != 16 || data_rd - d0 != 16) begin errors++; $display("FAIL f61_count: beats=%0d reads=%0d want 16/16", beat_dat.size() - b0, data_rd - d0); end
        if (beat_dat.size() - b0 == 16) begin
            bad = 0;
            for (int i = 0; i < 16; i++)
                if (beat_dat[b0+i] !== (32'hA5C30000 | (32'h800 + 32'(i)))) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL f61_data: %0d bad beats want 0", bad); end
            checks++; if (beat_keep[b0+15] !== 4'h1 || beat_last[b0+15] !== 1'b1) begin errors++; $display("FAIL f61_last: keep=%h tlast=%b want 1/1", beat_keep[b0+15], beat_last[b0+15]); end
        end
        checks++; if (stall_err != s0 || overlap_err != o0) begin errors++; $display("FAIL f61_stall: unstable=%0d bus_during_beat=%0d want 0/0", stall_err - s0, overlap_err - o0); end
    endtask

    task automatic test_frame_zero();
        int b0, d0, a0;
        bit done, clip, crc;
        logic [10:0] bytes;
        b0 = beat_dat.size(); d0 = data_rd; a0 = ack_cnt;
        run_frame(0, 1'b0, done, bytes, clip, crc);
        checks++; if (!done || bytes !== 11'd0) begin errors++; $display("FAIL f0_done: done=%b bytes=%0d want 1/0", done, bytes); end
        checks++; if (beat_dat.size() != b0 || data_rd != d0) begin errors++; $display("FAIL f0_beats: beats=%0d reads=%0d want 0/0", beat_dat.size() - b0, data_rd - d0); end
        checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL f0_ack: acks=%0d want 1", ack_cnt - a0); end
    endtask

    task automatic test_frame_clip();
        int b0, d0, bad;
        bit done, clip, crc;
        logic [10:0] bytes;
        b0 = beat_dat.size(); d0 = data_rd;
        run_frame(2047, 1'b0, done, bytes, clip, crc);
        checks++; if (!done || bytes !== 11'd1500 || clip !== 1'b1) begin errors++; $display("FAIL clip_done: done=%b bytes=%0d clip=%b want 1/1500/1", done, bytes, clip); end
        checks++; if (beat_dat.size() - b0 != 375 || data_rd - d0 != 375) begin errors++; $display("FAIL clip_count: beats=%0d reads=%0d want 375/375", beat_dat.size() - b0, data_rd - d0); end
        if (beat_dat.size() - b0 == 375) begin
            bad = 0;
            for (int i = 0; i < 375; i++)
                if (beat_dat[b0+i] !== (32'hA5C30000 | (32'h800 + 32'(i)))) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL clip_data: %0d bad beats want 0", bad); end
            checks++; if (beat_keep[b0+374] !== 4'hF || beat_last[b0+374] !== 1'b1) begin errors++; $display("FAIL clip_last: keep=%h tlast=%b want F/1", beat_keep[b0+374], beat_last[b0+374]); end
        end
        checks++; if (frame_bytes !== 11'd1500 || frame_clipped !== 1'b0) begin errors++; $display("FAIL clip_hold: bytes=%0d clip=%b want 1500/0", frame_bytes, frame_clipped); end
    endtask

`ifdef ETH_FRAME_READER_CRC_EN
    task automatic test_crc();
        int b0;
        bit done, clip, crc;
        logic [10:0] bytes;
        crc_val = CRC_G;
        run_frame(16, 1'b0, done, bytes, clip, crc);
        checks++; if (!done || crc !== 1'b1) begin errors++; $display("FAIL crc_good: done=%b ok=%b want 1/1", done, crc); end
        b0 = beat_dat.size();
        crc_val = 32'h0;
        run_frame(16, 1'b0, done, bytes, clip, crc);
        checks++; if (!done || crc !== 1'b0) begin errors++; $display("FAIL crc_bad: done=%b ok=%b want 1/0", done, crc); end
        checks++; if (beat_dat.size() - b0 != 4) begin errors++; $display("FAIL crc_bad_fwd: beats=%0d want 4", beat_dat.size() - b0); end
        crc_val = CRC_G;
    endtask
`endif

    task automatic test_reset_mid();
        int a0;
        bit seen;
        a0 = ack_cnt;
        size_val = 32'd64;
        ack_arm = ack_cnt;
        status_val = 32'h2;
        m_tready = 1'b1;
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (eth_valid && eth_addr == 12'h803) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach: RD_DATA word 3 not reached"); end
        rst_int = 1'b1;
        #1;
        checks++; if (eth_valid !== 1'b0 || busy !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 32'h0) begin errors++; $display("FAIL rstmid_out: valid=%b busy=%b tvalid=%b tdata=%h want 0", eth_valid, busy, m_tvalid, m_tdata); end
        checks++; if (frame_bytes !== 11'd0 || frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_status: bytes=%0d done=%b want 0/0", frame_bytes, frame_done); end
        en = 1'b0;
        status_val = 32'h0;
        @(negedge clk);
        rst_int = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (ack_cnt != a0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_noack: acks=%0d busy=%b want 0/0", ack_cnt - a0, busy); end
    endtask

    initial begin
        test_reset();
        test_idle_poll();
        test_frame_64();
        test_frame_61_stall();
        test_frame_zero();
        test_frame_clip();
`ifdef ETH_FRAME_READER_CRC_EN
        test_crc();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
